// File: rtl/recorder_pkg.sv
// Shared recorder definitions: default recording length and timer state encoding.
// Pure declarations, no latency; carries no flow-control behaviour.
// Imported by the recorder timing blocks.
package recorder_pkg;

    localparam int unsigned DEFAULT_N_SAMPLES = 4096;

    typedef enum logic {
        COUNTING = 1'b0,
        DONE     = 1'b1
    } timer_state_t;

endpackage

// File: rtl/rise_edge_detect.sv
// Rising-edge detector: one-cycle tick on each 0->1 transition of sig.
// Latency: combinational tick against a 1-cycle history register.
// Backpressure: none, a level held high yields a single tick.
module rise_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic sig,
    output logic tick
);

    logic sig_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig;
        end
    end

    // History clears in reset, so a level already high at release counts once.
    assign tick = sig & ~sig_q;

endmodule

// File: rtl/sample_timer.sv
// Recording-duration timer: counts D_done rising edges, sticky done_o after N_SAMPLES.
// Latency: count_o/done_o update on the clk edge that samples the qualifying edge.
// Backpressure: none; edges arriving after done are ignored until reset.
module sample_timer
    import recorder_pkg::*;
#(
    parameter int unsigned N_SAMPLES = DEFAULT_N_SAMPLES,
    parameter int unsigned CNT_W     = $clog2(N_SAMPLES + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             D_done,
    output logic             done_o,
    output logic [CNT_W-1:0] count_o
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SAMPLES - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(N_SAMPLES);

    timer_state_t     state;
    logic [CNT_W-1:0] count;
    logic             tick;

    rise_edge_detect u_done_edge (
        .clk   (clk),
        .rst_n (reset),
        .sig   (D_done),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= COUNTING;
            count <= '0;
        end else begin
            case (state)
                COUNTING: begin
                    if (tick) begin
                        if (count == LAST_CNT) begin
                            count <= FULL_CNT;
                            state <= DONE;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                // Terminal until reset: count parks at N_SAMPLES.
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= COUNTING;
                    count <= '0;
                end
            endcase
        end
    end

    assign done_o  = (state == DONE);
    assign count_o = count;

endmodule

// File: tb/tb_sample_timer.sv
// Scoreboard bench for sample_timer with N_SAMPLES=8: reference model pushes expected
// count/done per cycle, popped and compared half a cycle after each rising edge.
`timescale 1ns/1ps
module tb_sample_timer;

    localparam int N     = 8;
    localparam int CNT_W = $clog2(N + 1);

    typedef struct {
        int cnt;
        int done;
    } exp_t;

    logic             clk;
    logic             reset;
    logic             D_done;
    logic             done_o;
    logic [CNT_W-1:0] count_o;

    exp_t  exp_q[$];
    int    vec_cnt;
    int    err_cnt;
    string phase;

    int m_cnt;
    int m_done;
    bit m_prev;

    sample_timer #(.N_SAMPLES(N)) dut (
        .clk     (clk),
        .reset   (reset),
        .D_done  (D_done),
        .done_o  (done_o),
        .count_o (count_o)
    );

    initial clk = 1'b0;
    always #1 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s.%s got=%0d expected=%0d at %0t", phase, tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt  = 0;
        m_done = 0;
        m_prev = 1'b0;
    endtask

    task automatic pop_and_check();
        exp_t e;
        if (exp_q.size() == 0) begin
            chk("queue_empty", 1, 0);
        end else begin
            e = exp_q.pop_front();
            chk("count", int'(count_o), e.cnt);
            chk("done", int'(done_o), e.done);
        end
    endtask

    // Drive one cycle of D_done, predict the post-edge state, compare after the edge.
    task automatic step(input logic d);
        exp_t e;
        D_done = d;
        if (!reset) begin
            model_reset();
        end else begin
            if (d && !m_prev && m_done == 0) begin
                m_cnt++;
                if (m_cnt == N) m_done = 1;
            end
            m_prev = d;
        end
        e.cnt  = m_cnt;
        e.done = m_done;
        exp_q.push_back(e);
        @(posedge clk);
        #0.5;
        pop_and_check();
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1);
            step(1'b0);
        end
    endtask

    // Assert reset between edges and expect outputs to clear before any clk edge.
    task automatic async_reset();
        exp_t e;
        reset = 1'b0;
        model_reset();
        e.cnt  = 0;
        e.done = 0;
        exp_q.push_back(e);
        #0.2;
        pop_and_check();
        for (int i = 0; i < 5; i++) step(1'b0);
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        reset   = 1'b0;
        D_done  = 1'b0;
        model_reset();

        phase = "reset_hold";
        #0.5;
        chk("count0", int'(count_o), 0);
        chk("done0", int'(done_o), 0);
        for (int i = 0; i < 50; i++) step(((i / 3) % 2) == 1);

        phase = "first_run";
        D_done = 1'b0;
        reset  = 1'b1;
        pulses(N);

        phase = "after_done";
        pulses(5);
        step(1'b1);
        for (int i = 0; i < 4; i++) step(1'b1);
        step(1'b0);

        phase = "async_from_done";
        async_reset();

        phase = "mid_run";
        pulses(5);
        phase = "async_mid_run";
        async_reset();

        phase = "rerun";
        pulses(N - 1);
        step(1'b0);
        pulses(1);
        step(1'b0);

        phase = "hold_high";
        async_reset();
        for (int i = 0; i < 10; i++) step(1'b1);
        for (int i = 0; i < 3; i++) step(1'b0);
        pulses(2);

        phase = "high_at_release";
        reset = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b1);
        reset = 1'b1;
        step(1'b1);
        step(1'b1);
        step(1'b0);
        pulses(N - 1);
        step(1'b0);

        if (exp_q.size() != 0) chk("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/sample_timer.md
Name: sample_timer

Overview:
- Recording-duration timer for the audio recorder datapath.
- Counts completed-sample strobes (D_done) from the converter interface.
- Raises a sticky done_o once a fixed number of samples has elapsed, which tells the recorder FSM to stop record/playback.
- Restarted only by reset.

Parameters:
- N_SAMPLES, 4096: number of D_done rising edges that make up one recording interval. Legal range is 1 .. 2^24-1.
- CNT_W, $clog2(N_SAMPLES+1): sample counter width. Derived; not overridden by users.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = held in reset).
- D_done  input  1  sample-complete strobe from the converter. Level signal, synchronous to clk, may stay high for several cycles.
- done_o  output  1  high once N_SAMPLES samples have been counted. Sticky until reset.
- count_o  output  CNT_W  current sample count, for debug/status.

Behaviour:
- Reset (reset=0, asynchronous):
  - count=0, done_o=0, D_done history register=0.
  - Outputs clear immediately on assertion, without waiting for a clk edge.
  - Release is taken at the next clk edge.
- Edge detection:
  - tick = D_done & ~D_done_q, where D_done_q is D_done registered on clk.
  - A D_done held high for k cycles produces exactly one tick.
  - D_done already high when reset releases: D_done_q is 0 after reset, so this counts as one tick in the first cycle.
- Counting:
  - When tick=1 and done_o=0, count <= count+1 on that clk edge.
  - count_o reflects the registered count.
  - count never exceeds N_SAMPLES and never wraps.
- Completion:
  - When tick=1 and count==N_SAMPLES-1, then on that same edge: count <= N_SAMPLES and done_o <= 1.
  - done_o is therefore high in the cycle after the N-th tick is registered (one clk latency from the qualifying D_done sample).
- After done:
  - Ticks are ignored; count holds at N_SAMPLES; done_o stays 1.
  - The only way out is reset=0.
- Reset mid-operation: count and done_o are lost and counting restarts from 0 after release.
- N_SAMPLES=1: the first tick sets done_o.
- States, implemented as two-state FSM encoding or equivalently as the done_o flag:
  - COUNTING: done_o=0. Goes to DONE on the N-th tick.
  - DONE: done_o=1. Goes to COUNTING only via reset.
- No X propagation: all registers are reset.

Decomposition:
- Shared package recorder_pkg:
  - default sample-count constant (DEFAULT_N_SAMPLES=4096);
  - timer state enum {COUNTING, DONE}.
- One natural sub-module: rise_edge_detect (1-bit register plus AND gate, with async active-low reset). Reused by other recorder blocks for strobe edges.
- The counter and done flag live in sample_timer.

Test Plan (N_SAMPLES=8, clk period 2 ns):
- Hold reset=0 for 100 ns while D_done toggles every 3 cycles -> done_o=0 and count_o=0 throughout.
- Release reset, apply exactly 8 single-cycle D_done pulses -> count_o steps 1..8; done_o rises one cycle after the 8th pulse is sampled.
- After done, apply 5 more pulses -> count_o stays 8, done_o stays 1.
- Hold D_done high for 10 cycles, then low -> count increments by exactly 1.
- After 5 pulses, assert reset=0 for 10 ns between clk edges -> count_o=0 and done_o=0 immediately (asynchronously). After release, 8 new pulses are needed to set done_o.
- D_done=1 at reset release -> counted as one tick (count_o=1 after first clk edge).
